// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - seven-segment pattern constants and segment-to-BCD decode
package disp_pkg;

  localparam logic [6:0] SSEG_0 = 7'b1000000;
  localparam logic [6:0] SSEG_1 = 7'b1111001;
  localparam logic [6:0] SSEG_2 = 7'b0100100;
  localparam logic [6:0] SSEG_3 = 7'b0110000;
  localparam logic [6:0] SSEG_4 = 7'b0011001;
  localparam logic [6:0] SSEG_5 = 7'b0010010;
  localparam logic [6:0] SSEG_6 = 7'b0000010;
  localparam logic [6:0] SSEG_7 = 7'b1111000;
  localparam logic [6:0] SSEG_8 = 7'b0000000;
  localparam logic [6:0] SSEG_9 = 7'b0010000;

  localparam logic [3:0] SSEG_BLANK_AN = 4'hF;

  typedef struct packed {
    logic       legal;
    logic [3:0] bcd;
  } seg_dec_t;

  function automatic seg_dec_t sseg_to_bcd(input logic [6:0] seg);
    seg_dec_t r;
    r.legal = 1'b1;
    r.bcd   = 4'd0;
    case (seg)
      SSEG_0:  r.bcd = 4'd0;
      SSEG_1:  r.bcd = 4'd1;
      SSEG_2:  r.bcd = 4'd2;
      SSEG_3:  r.bcd = 4'd3;
      SSEG_4:  r.bcd = 4'd4;
      SSEG_5:  r.bcd = 4'd5;
      SSEG_6:  r.bcd = 4'd6;
      SSEG_7:  r.bcd = 4'd7;
      SSEG_8:  r.bcd = 4'd8;
      SSEG_9:  r.bcd = 4'd9;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  // True when exactly one bit of sel is set (sel is the inverted anode bus).
  function automatic logic is_one_hot(input logic [3:0] sel);
    return (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/sseg_dwell.sv
// rtl/sseg_dwell.sv - input registers and stability dwell counter for the display bus
module sseg_dwell
  import disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [3:0] an_q,
  output logic [7:0] sseg_q,
  output logic       capture_stb
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed;

  // The counter tracks how long the registered value has held, so it is
  // cleared on the same edge that loads a new value into an_q/sseg_q.
  always_comb begin
    changed     = ({an, sseg} != {an_q, sseg_q});
    cnt_d       = cnt_q;
    capture_stb = 1'b0;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (!changed && (cnt_q == CNT_CAP)) begin
      capture_stb = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= SSEG_BLANK_AN;
      sseg_q <= 8'hFF;
      cnt_q  <= '0;
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_demux.sv
// rtl/disp_demux.sv - rebuilds four BCD digits from a multiplexed seven-segment bus
module disp_demux
  import disp_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] bcd,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err
);

  logic [3:0]  an_q;
  logic [7:0]  sseg_q;
  logic        capture_stb;

  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        err_q, err_d;

  logic [3:0]  sel;
  logic [3:0]  seen_n;
  seg_dec_t    dec;

  sseg_dwell #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .sseg       (sseg),
    .an_q       (an_q),
    .sseg_q     (sseg_q),
    .capture_stb(capture_stb)
  );

  always_comb begin
    sel     = ~an_q;
    dec     = sseg_to_bcd(sseg_q[6:0]);
    seen_n  = seen_q | sel;
    bcd_d   = bcd_q;
    dp_d    = dp_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    frame_d = 1'b0;
    err_d   = 1'b0;
    if (capture_stb && (an_q != SSEG_BLANK_AN)) begin
      if (is_one_hot(sel)) begin
        dp_d = (dp_q & ~sel) | (sel & {4{~sseg_q[7]}});
        if (dec.legal) begin
          valid_d = valid_q | sel;
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
              bcd_d[4*i +: 4] = dec.bcd;
            end
          end
        end else begin
          // An undecodable digit still counts as refreshed for the frame.
          valid_d = valid_q & ~sel;
          err_d   = 1'b1;
        end
        if (seen_n == 4'hF) begin
          frame_d = 1'b1;
          seen_d  = 4'h0;
        end else begin
          seen_d  = seen_n;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q   <= 16'h0;
      dp_q    <= 4'h0;
      valid_q <= 4'h0;
      seen_q  <= 4'h0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      dp_q    <= dp_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign bcd         = bcd_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err         = err_q;

endmodule

// File: tb/tb_disp_demux.sv
// tb/tb_disp_demux.sv - directed self-checking bench for disp_demux
module tb_disp_demux;

  logic        clk;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        err;

  int checks;
  int failures;
  int err_cnt;
  int frame_cnt;
  int both_cnt;

  disp_demux #(.STABLE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .an         (an),
    .sseg       (sseg),
    .bcd        (bcd),
    .dp         (dp),
    .digit_valid(digit_valid),
    .frame_valid(frame_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (frame_valid) frame_cnt++;
    if (err && frame_valid) both_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    an   = a;
    sseg = s;
    step(n);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 8'hFF;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b1;
    an    = 4'b1110;
    sseg  = 8'hC0;
    step(3);
    checks++;
    if ({bcd, dp, digit_valid, frame_valid, err} !== 26'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {bcd, dp, digit_valid, frame_valid, err});
    end
    reset = 1'b0;
    first = 0;
    for (int c = 1; c <= 40 && first == 0; c++) begin
      step(1);
      if (digit_valid[0]) first = c;
    end
    checks++;
    if (first != 17) begin
      failures++;
      $display("FAIL reset_latency got=%0d exp=17", first);
    end
    checks++;
    if (bcd[3:0] !== 4'd0) begin
      failures++;
      $display("FAIL reset_digit0 got=%h exp=0", bcd[3:0]);
    end
  endtask

  task automatic test_single_digit();
    int e0, f0, first;
    apply_reset();
    e0 = err_cnt; f0 = frame_cnt;
    an = 4'b1110; sseg = 8'hA4;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      if (digit_valid[0] && first == 0) first = c;
    end
    checks++;
    if (first != 17) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=17", first);
    end
    checks++;
    if (bcd[3:0] !== 4'd2 || digit_valid !== 4'b0001 || dp !== 4'b0000) begin
      failures++;
      $display("FAIL single_value got bcd=%h valid=%b dp=%b exp bcd0=2 valid=0001 dp=0000", bcd, digit_valid, dp);
    end
    checks++;
    if (frame_cnt - f0 != 0 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL single_pulses got frame=%0d err=%0d exp 0 0", frame_cnt - f0, err_cnt - e0);
    end
  endtask

  task automatic test_full_frame();
    int f0, e0;
    apply_reset();
    f0 = frame_cnt; e0 = err_cnt;
    hold(4'b0111, 8'h90, 32);
    hold(4'b1011, 8'h12, 32);
    hold(4'b1101, 8'hC0, 32);
    checks++;
    if (frame_cnt - f0 != 0) begin
      failures++;
      $display("FAIL frame_early got=%0d exp=0", frame_cnt - f0);
    end
    hold(4'b1110, 8'hF8, 32);
    checks++;
    if (bcd !== 16'h9507 || dp !== 4'b0100 || digit_valid !== 4'hF) begin
      failures++;
      $display("FAIL frame_values got bcd=%h dp=%b valid=%b exp 9507 0100 1111", bcd, dp, digit_valid);
    end
    checks++;
    if (frame_cnt - f0 != 1 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL frame_pulse got frame=%0d err=%0d exp 1 0", frame_cnt - f0, err_cnt - e0);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    an = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      sseg = (i % 2 == 0) ? 8'hC0 : 8'hF9;
      step(5);
    end
    checks++;
    if (digit_valid !== 4'h0 || err_cnt < 0) begin
      failures++;
      $display("FAIL glitch_nocap got=%b exp=0000", digit_valid);
    end
    hold(4'b1101, 8'hA4, 16);
    checks++;
    if (digit_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL glitch_early got=%b exp=0", digit_valid[1]);
    end
    step(1);
    checks++;
    if (digit_valid !== 4'b0010 || bcd[7:4] !== 4'd2) begin
      failures++;
      $display("FAIL glitch_capture got valid=%b bcd1=%h exp 0010 2", digit_valid, bcd[7:4]);
    end
  endtask

  task automatic test_errors();
    int e0, f0, b0;
    apply_reset();
    e0 = err_cnt; f0 = frame_cnt; b0 = both_cnt;
    hold(4'b1100, 8'hC0, 20);
    checks++;
    if (err_cnt - e0 != 1 || digit_valid !== 4'h0 || bcd !== 16'h0) begin
      failures++;
      $display("FAIL err_anode got err=%0d valid=%b bcd=%h exp 1 0000 0000", err_cnt - e0, digit_valid, bcd);
    end
    hold(4'b0111, 8'h90, 20);
    hold(4'b0111, 8'hFF, 20);
    checks++;
    if (err_cnt - e0 != 2 || digit_valid !== 4'h0 || bcd[15:12] !== 4'd9 || dp[3] !== 1'b0) begin
      failures++;
      $display("FAIL err_segment got err=%0d valid=%b bcd3=%h dp3=%b exp 2 0000 9 0", err_cnt - e0, digit_valid, bcd[15:12], dp[3]);
    end
    hold(4'b1110, 8'hC0, 20);
    hold(4'b1101, 8'hF9, 20);
    checks++;
    if (frame_cnt - f0 != 0) begin
      failures++;
      $display("FAIL err_frame_early got=%0d exp=0", frame_cnt - f0);
    end
    hold(4'b1011, 8'h7F, 20);
    checks++;
    if (frame_cnt - f0 != 1 || both_cnt - b0 != 1 || err_cnt - e0 != 3) begin
      failures++;
      $display("FAIL err_frame_joint got frame=%0d both=%0d err=%0d exp 1 1 3", frame_cnt - f0, both_cnt - b0, err_cnt - e0);
    end
    checks++;
    if (digit_valid !== 4'b0011 || dp !== 4'b0100 || bcd !== 16'h9010) begin
      failures++;
      $display("FAIL err_final got valid=%b dp=%b bcd=%h exp 0011 0100 9010", digit_valid, dp, bcd);
    end
  endtask

  task automatic test_blank_reset_mid_dwell();
    int e0;
    apply_reset();
    e0 = err_cnt;
    hold(4'hF, 8'hC0, 20);
    checks++;
    if (digit_valid !== 4'h0 || err_cnt - e0 != 0) begin
      failures++;
      $display("FAIL blank got valid=%b err=%0d exp 0000 0", digit_valid, err_cnt - e0);
    end
    hold(4'b1110, 8'hF9, 11);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(16);
    checks++;
    if (digit_valid !== 4'h0 || bcd !== 16'h0) begin
      failures++;
      $display("FAIL midreset_clear got valid=%b bcd=%h exp 0000 0000", digit_valid, bcd);
    end
    step(1);
    checks++;
    if (digit_valid !== 4'b0001 || bcd[3:0] !== 4'd1) begin
      failures++;
      $display("FAIL midreset_recapture got valid=%b bcd0=%h exp 0001 1", digit_valid, bcd[3:0]);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    err_cnt   = 0;
    frame_cnt = 0;
    both_cnt  = 0;
    reset     = 1'b1;
    an        = 4'hF;
    sseg      = 8'hFF;
    test_reset();
    test_single_digit();
    test_full_frame();
    test_glitch();
    test_errors();
    test_blank_reset_mid_dwell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_demux.md
Name: disp_demux

Overview:
- Receive-side counterpart of the seven-segment display multiplexer: watches the time-multiplexed anode strobes and segment bus, and rebuilds the four displayed digits.
- Decodes each segment pattern back to BCD, which inverts the bcd_decoder mapping.
- Used in loopback self-test and as a synthesizable monitor on the stopwatch display path.
- Output: per-digit BCD values with valid/dp flags, plus a one-cycle frame strobe when all four digits have been refreshed.

Parameters:
- STABLE_CYCLES, 16: consecutive identical samples of {an, sseg} required before a digit is captured. Legal range is 2 or more.
- CNT_W, $clog2(STABLE_CYCLES+1): dwell counter width. Derived value; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- an  input  4  anode strobes, active-low; an[i]=0 selects digit i
- sseg  input  8  segments, active-low; sseg[6:0]={g,f,e,d,c,b,a}, sseg[7]=dp
- bcd  output  16  {bcd3,bcd2,bcd1,bcd0}, last captured BCD per digit
- dp  output  4  last captured decimal point per digit, active-high (1 = dp lit)
- digit_valid  output  4  digit i holds a legal decoded value
- frame_valid  output  1  one-cycle pulse: all four digits captured since the previous pulse
- err  output  1  one-cycle pulse: illegal anode pattern, or undecodable segment pattern, at a capture point

Behaviour:
- Reset (sync, active-high): bcd=0, dp=0, digit_valid=0, frame_valid=0, err=0, seen mask=0, dwell counter=0, input registers=4'hF/8'hFF.
- Input stage: an and sseg are registered once (an_q, sseg_q). All logic below uses the registered values.
- Dwell counter:
  - Clears to 0 whenever {an_q, sseg_q} differs from its value on the previous cycle.
  - Otherwise it increments and saturates at STABLE_CYCLES.
- Capture point: the cycle the counter transitions from STABLE_CYCLES-1 to STABLE_CYCLES. Exactly one capture per stable dwell; no recapture until the inputs change.
- Anode classification at a capture point:
  - an_q=4'b1111 (blank): no capture, no error.
  - Exactly one zero at index i (one-hot-low): capture into digit i.
  - Any other value: err pulse; no register updates.
- Segment decode (sseg_q[6:0], active-low) to BCD:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4
  - 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9
- On capture to digit i:
  - Legal pattern: bcd_i=value, dp[i]=~sseg_q[7], digit_valid[i]=1, seen[i]=1.
  - Illegal pattern: digit_valid[i]=0, bcd_i holds its old value, dp[i] updates, seen[i]=1, err pulses.
- Latency: bcd, digit_valid and dp update 1+STABLE_CYCLES cycles after the pins become stable (1 input register + dwell). Outputs are registered and change the cycle after the capture point.
- Frame strobe:
  - When a capture makes seen==4'hF, frame_valid pulses that same output cycle and seen clears to 0.
  - Re-capturing a digit already in seen does not pulse frame_valid.
- Simultaneous events: err and frame_valid may pulse in the same cycle, since an illegal-pattern capture still completes a frame.
- Reset mid-dwell: reset wins, and all state returns to reset values.

Decomposition:
- Shared package disp_pkg:
  - Segment-pattern constants SSEG_0..SSEG_9 (active-low, {g..a}) and SSEG_BLANK_AN=4'hF.
  - A decode function sseg_to_bcd returning {legal, bcd[3:0]}; bcd_decoder also reuses these constants.
- Sub-module: sseg_dwell (input registers plus dwell counter; outputs capture_stb, an_q, sseg_q).
- The top holds classification, the digit registers and the frame logic.

Test Plan:
1. Reset: hold reset 3 cycles with an=4'b1110, sseg=8'hC0 → all outputs 0; no capture until STABLE_CYCLES+1 cycles after reset deasserts.
2. Single digit: an=4'b1110, sseg=8'hA4 held 20 cycles → bcd[3:0]=2, digit_valid=4'b0001, dp[0]=0, exactly one capture, no frame_valid.
3. Full frame: drive digits 3,2,1,0 = 9,5,0,7 (sseg 0x90,0x92,0xC0,0xF8; digit 2 with dp, i.e. sseg 0x12), 32 cycles each → bcd=16'h9507, dp=4'b0100, digit_valid=4'hF, one frame_valid pulse when the 4th digit is captured.
4. Glitch rejection: toggle sseg every 5 cycles on an=4'b1101 → no capture; then hold 16 cycles → capture.
5. Errors: an=4'b1100 held 20 cycles → err pulses once, outputs unchanged. an=4'b0111 with sseg=8'hFF → err, digit_valid[3]=0, seen[3] set.
6. Blank and reset mid-dwell: an=4'hF held → no capture, no err. Assert reset at dwell count 10 → counter and outputs cleared.
